// File: rtl/ycbcr_422_packer.sv
// Pairs adjacent YCbCr pixels into a 4:2:2 beat stream (Y0,Cb_avg) then (Y1,Cr_avg).
// Completed pairs are buffered in a FIFO; drops on a full FIFO raise a sticky overflow flag.
module ycbcr_422_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 data_valid_in,
    input  logic [DATA_WIDTH-1:0]                y_in,
    input  logic [DATA_WIDTH-1:0]                cb_in,
    input  logic [DATA_WIDTH-1:0]                cr_in,
    input  logic                                 line_end_in,
    input  logic                                 out_ready,
    output logic                                 out_valid,
    output logic [DATA_WIDTH-1:0]                y_out,
    output logic [DATA_WIDTH-1:0]                c_out,
    output logic                                 c_sel_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
    output logic                                 overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = DATA_WIDTH;
    localparam int EW = 4 * DATA_WIDTH;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [DW:0]   ROUND_ONE  = (DW+1)'(1);

    typedef enum logic {
        PAIR_EVEN,
        PAIR_ODD
    } pair_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_BEAT0,
        OUT_BEAT1
    } out_state_t;

    pair_state_t r_pairState, w_pairNext;
    out_state_t  r_outState, w_outNext;

    logic [DW-1:0] r_y0, r_cb0, r_cr0;
    logic [DW:0]   w_cbSum, w_crSum;
    logic [DW-1:0] w_pairY0, w_pairY1, w_pairCb, w_pairCr;
    logic [EW-1:0] w_pairWord;
    logic          w_pairDone;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [LW-1:0] r_wrPtr, r_rdPtr;
    logic [LW-1:0] w_level;
    logic [EW-1:0] w_head;
    logic          w_fifoEmpty, w_fifoFull, w_fifoWrite, w_pop;
    logic          r_overflow;

    logic [DW-1:0] r_yOut, r_cOut, r_y1Hold, r_crHold;
    logic          r_cSel;
    logic [DW-1:0] w_yNext, w_cNext, w_y1Next, w_crNext;
    logic          w_selNext;

    // A pair completes on the ODD pixel, or immediately on an EVEN pixel that ends a line.
    always_comb begin
        w_pairNext = r_pairState;
        w_pairDone = 1'b0;
        if (data_valid_in) begin
            if (r_pairState == PAIR_EVEN) begin
                w_pairDone = line_end_in;
                w_pairNext = line_end_in ? PAIR_EVEN : PAIR_ODD;
            end else begin
                w_pairDone = 1'b1;
                w_pairNext = PAIR_EVEN;
            end
        end
    end

    assign w_cbSum = {1'b0, r_cb0} + {1'b0, cb_in} + ROUND_ONE;
    assign w_crSum = {1'b0, r_cr0} + {1'b0, cr_in} + ROUND_ONE;

    always_comb begin
        w_pairY0 = r_y0;
        w_pairY1 = y_in;
        w_pairCb = DW'(w_cbSum >> 1);
        w_pairCr = DW'(w_crSum >> 1);
        if (r_pairState == PAIR_EVEN) begin
            w_pairY0 = y_in;
            w_pairCb = cb_in;
            w_pairCr = cr_in;
        end
    end

    assign w_pairWord = {w_pairY0, w_pairY1, w_pairCb, w_pairCr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pairState <= PAIR_EVEN;
            r_y0        <= '0;
            r_cb0       <= '0;
            r_cr0       <= '0;
        end else begin
            r_pairState <= w_pairNext;
            if (data_valid_in && r_pairState == PAIR_EVEN) begin
                r_y0  <= y_in;
                r_cb0 <= cb_in;
                r_cr0 <= cr_in;
            end
        end
    end

    // A full FIFO drops the pair even if a pop happens on the same edge.
    assign w_level     = r_wrPtr - r_rdPtr;
    assign w_fifoEmpty = (w_level == '0);
    assign w_fifoFull  = (w_level == FULL_LEVEL);
    assign w_fifoWrite = w_pairDone && !w_fifoFull;
    assign w_head      = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_fifoWrite) begin
            r_mem[r_wrPtr[AW-1:0]] <= w_pairWord;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_fifoWrite) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_pairDone && w_fifoFull) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // BEAT1 pops the next entry straight into BEAT0 so back-to-back pairs have no bubble.
    always_comb begin
        w_outNext = r_outState;
        w_pop     = 1'b0;
        w_yNext   = r_yOut;
        w_cNext   = r_cOut;
        w_selNext = r_cSel;
        w_y1Next  = r_y1Hold;
        w_crNext  = r_crHold;
        case (r_outState)
            OUT_IDLE: begin
                if (!w_fifoEmpty) begin
                    w_pop = 1'b1;
                    w_outNext = OUT_BEAT0;
                end
            end
            OUT_BEAT0: begin
                if (out_ready) begin
                    w_outNext = OUT_BEAT1;
                    w_yNext   = r_y1Hold;
                    w_cNext   = r_crHold;
                    w_selNext = 1'b1;
                end
            end
            OUT_BEAT1: begin
                if (out_ready) begin
                    if (!w_fifoEmpty) begin
                        w_pop = 1'b1;
                        w_outNext = OUT_BEAT0;
                    end else begin
                        w_outNext = OUT_IDLE;
                    end
                end
            end
            default: w_outNext = OUT_IDLE;
        endcase
        if (w_pop) begin
            w_yNext   = w_head[EW-1 -: DW];
            w_y1Next  = w_head[3*DW-1 -: DW];
            w_cNext   = w_head[2*DW-1 -: DW];
            w_crNext  = w_head[DW-1:0];
            w_selNext = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outState <= OUT_IDLE;
            r_yOut     <= '0;
            r_cOut     <= '0;
            r_cSel     <= 1'b0;
            r_y1Hold   <= '0;
            r_crHold   <= '0;
        end else begin
            r_outState <= w_outNext;
            r_yOut     <= w_yNext;
            r_cOut     <= w_cNext;
            r_cSel     <= w_selNext;
            r_y1Hold   <= w_y1Next;
            r_crHold   <= w_crNext;
        end
    end

    assign out_valid  = (r_outState != OUT_IDLE);
    assign y_out      = r_yOut;
    assign c_out      = r_cOut;
    assign c_sel_out  = r_cSel;
    assign fifo_level = w_level;
    assign overflow   = r_overflow;

endmodule
